// File: rtl/dmi_pkg.sv
// +--------------------------------------------------------------------+
// | dmi_pkg: shared DMI op/resp codes, request/response structs, states |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package dmi_pkg;

  localparam int unsigned DMI_ADDR_W = 9;
  localparam int unsigned DMI_DATA_W = 32;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam logic [1:0] DMI_RSP_OK     = 2'd0;
  localparam logic [1:0] DMI_RSP_FAILED = 2'd2;
  localparam logic [1:0] DMI_RSP_BUSY   = 2'd3;

  typedef struct packed {
    logic [DMI_ADDR_W-1:0] addr;
    logic [DMI_DATA_W-1:0] data;
    logic [1:0]            op;
  } dmi_req_t;

  typedef struct packed {
    logic [DMI_DATA_W-1:0] data;
    logic [1:0]            resp;
  } dmi_rsp_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dmi_req_arbiter_if.sv
// +--------------------------------------------------------------------+
// | dmi_req_arbiter_if: N-lane DMI request/response channel bundle     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface dmi_req_arbiter_if #(
  parameter int unsigned N      = 1,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
);
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N*ADDR_W-1:0] req_addr;
  logic [N*DATA_W-1:0] req_data;
  logic [2*N-1:0]      req_op;
  logic [N-1:0]        rsp_valid;
  logic [N-1:0]        rsp_ready;
  logic [DATA_W-1:0]   rsp_data;
  logic [1:0]          rsp_resp;

  modport master (
    output req_valid, req_addr, req_data, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_resp
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_resp
  );
endinterface

`default_nettype wire

// File: rtl/dmi_rr_arb2.sv
// +--------------------------------------------------------------------+
// | dmi_rr_arb2: two-way round-robin grant with toggling priority ptr  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module dmi_rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       winner
);

  logic ptr;

  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) winner = ptr;
    else if (req[1])  winner = 1'b1;
    grant = (en && (|req)) ? (winner ? 2'b10 : 2'b01) : 2'b00;
  end

  // Priority passes to the loser of every grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     ptr <= 1'b0;
    else if (|grant)  ptr <= ~winner;
  end

endmodule

`default_nettype wire

// File: rtl/dmi_req_arbiter.sv
// +--------------------------------------------------------------------+
// | dmi_req_arbiter: 2:1 round-robin DMI arbiter, one txn outstanding. |
// | Optional response timeout: define DMI_ARB_TIMEOUT_EN.  Rev 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module dmi_req_arbiter
  import dmi_pkg::*;
#(
  parameter int unsigned ADDR_W         = DMI_ADDR_W,
  parameter int unsigned DATA_W         = DMI_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic              clock,
  input  logic              reset_n,
  dmi_req_arbiter_if.slave  up,
  dmi_req_arbiter_if.master dn,
  output logic              owner,
  output logic              busy
);

  state_e     state, state_nx;
  dmi_req_t   req_q;
  dmi_rsp_t   rsp_q;
  logic       owner_q;
  logic [1:0] grant;
  logic       win;
  logic       rsp_take;
  logic       to_fire;
  logic       rsp_accept;

  dmi_rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (state == ST_IDLE),
    .req     (up.req_valid),
    .grant   (grant),
    .winner  (win)
  );

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             drop_pending;

  // A response racing the final count wins over the timeout.
  assign rsp_take   = (state == ST_WAIT) && dn.rsp_valid && !drop_pending;
  assign to_fire    = (state == ST_WAIT) && !rsp_take &&
                      (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_accept = (state == ST_WAIT) || drop_pending;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt     <= '0;
      drop_pending <= 1'b0;
    end else begin
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + CNT_W'(1) : '0;
      if (to_fire)                          drop_pending <= 1'b1;
      else if (drop_pending && dn.rsp_valid) drop_pending <= 1'b0;
    end
  end
`else
  assign rsp_take   = (state == ST_WAIT) && dn.rsp_valid;
  assign to_fire    = 1'b0;
  assign rsp_accept = (state == ST_WAIT);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    up.req_ready = grant;
    up.rsp_valid = 2'b00;
    dn.req_valid = 1'b0;
    dn.rsp_ready = rsp_accept;
    busy         = (state != ST_IDLE);
    unique case (state)
      ST_IDLE:    if (|grant) state_nx = ST_ISSUE;
      ST_ISSUE: begin
        dn.req_valid = 1'b1;
        if (dn.req_ready) state_nx = ST_WAIT;
      end
      ST_WAIT:    if (rsp_take || to_fire) state_nx = ST_DELIVER;
      ST_DELIVER: begin
        up.rsp_valid = owner_q ? 2'b10 : 2'b01;
        if (up.rsp_ready[owner_q]) state_nx = ST_IDLE;
      end
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_q   <= '0;
      rsp_q   <= '0;
      owner_q <= 1'b0;
    end else begin
      if (|grant) begin
        req_q.addr <= DMI_ADDR_W'(up.req_addr[win*ADDR_W +: ADDR_W]);
        req_q.data <= DMI_DATA_W'(up.req_data[win*DATA_W +: DATA_W]);
        req_q.op   <= up.req_op[win*2 +: 2];
        owner_q    <= win;
      end
      if (rsp_take) begin
        rsp_q.data <= DMI_DATA_W'(dn.rsp_data);
        rsp_q.resp <= dn.rsp_resp;
      end else if (to_fire) begin
        rsp_q.data <= '0;
        rsp_q.resp <= DMI_RSP_FAILED;
      end
    end
  end

  assign dn.req_addr = ADDR_W'(req_q.addr);
  assign dn.req_data = DATA_W'(req_q.data);
  assign dn.req_op   = req_q.op;
  assign up.rsp_data = DATA_W'(rsp_q.data);
  assign up.rsp_resp = rsp_q.resp;
  assign owner       = owner_q;

  // A downstream beat must never arrive when nobody is ready to take it.
  a_no_stray_rsp: assert property (@(posedge clock) disable iff (!reset_n)
    dn.rsp_valid |-> dn.rsp_ready);

endmodule

`default_nettype wire

// File: tb/tb_dmi_req_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_dmi_req_arbiter: directed self-checking bench for the arbiter   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dmi_req_arbiter;
  import dmi_pkg::*;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;

  logic clock;
  logic reset_n;
  logic owner;
  logic busy;
  int   n_tests;
  int   n_fail;

  dmi_req_arbiter_if #(.N(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) up_if ();
  dmi_req_arbiter_if #(.N(1), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dn_if ();

  dmi_req_arbiter #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .up      (up_if),
    .dn      (dn_if),
    .owner   (owner),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Downstream accepts the pending request, then returns one response beat.
  task automatic dm_complete(input logic [31:0] d, input logic [1:0] r);
    dn_if.req_ready = 1'b1;
    tick();
    dn_if.req_ready = 1'b0;
    dn_if.rsp_valid = 1'b1;
    dn_if.rsp_data  = d;
    dn_if.rsp_resp  = r;
    tick();
    dn_if.rsp_valid = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    up_if.req_valid = '0;
    up_if.req_addr  = '0;
    up_if.req_data  = '0;
    up_if.req_op    = '0;
    up_if.rsp_ready = '0;
    dn_if.req_ready = 1'b0;
    dn_if.rsp_valid = 1'b0;
    dn_if.rsp_data  = '0;
    dn_if.rsp_resp  = '0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;

    check("rst_req_ready", up_if.req_ready, 2'b00);
    check("rst_rsp_valid", up_if.rsp_valid, 2'b00);
    check("rst_dm_req_valid", dn_if.req_valid, 1'b0);
    check("rst_dm_rsp_ready", dn_if.rsp_ready, 1'b0);
    check("rst_owner", owner, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Single read from requester 0.
    up_if.req_valid = 2'b01;
    up_if.req_addr  = {9'h000, 9'h011};
    up_if.req_op    = {DMI_OP_NOP, DMI_OP_READ};
    #1;
    check("t1_req_ready", up_if.req_ready, 2'b01);
    tick();
    up_if.req_valid = 2'b00;
    check("t1_dm_req_valid", dn_if.req_valid, 1'b1);
    check("t1_dm_req_addr", dn_if.req_addr, 9'h011);
    check("t1_dm_req_op", dn_if.req_op, DMI_OP_READ);
    check("t1_owner", owner, 1'b0);
    check("t1_busy", busy, 1'b1);
    dn_if.req_ready = 1'b1;
    tick();
    dn_if.req_ready = 1'b0;
    check("t1_dm_rsp_ready", dn_if.rsp_ready, 1'b1);
    dn_if.rsp_valid = 1'b1;
    dn_if.rsp_data  = 32'hDEAD_BEEF;
    dn_if.rsp_resp  = DMI_RSP_OK;
    tick();
    dn_if.rsp_valid = 1'b0;
    check("t1_rsp_valid", up_if.rsp_valid, 2'b01);
    check("t1_rsp_data", up_if.rsp_data, 32'hDEAD_BEEF);
    check("t1_rsp_resp", up_if.rsp_resp, DMI_RSP_OK);
    up_if.rsp_ready = 2'b01;
    tick();
    check("t1_idle_busy", busy, 1'b0);
    check("t1_idle_rsp_valid", up_if.rsp_valid, 2'b00);

    // Fresh reset so the pointer favours requester 0 again.
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();

    // Both requesters hold writes: grants must alternate 0,1,0,1.
    up_if.rsp_ready = 2'b11;
    up_if.req_valid = 2'b11;
    up_if.req_addr  = {9'h0B0, 9'h0A0};
    up_if.req_data  = {32'h1111_1111, 32'h2222_2222};
    up_if.req_op    = {DMI_OP_WRITE, DMI_OP_WRITE};
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2_req_ready", up_if.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      check("t2_owner", owner, (k % 2 == 0) ? 1'b0 : 1'b1);
      check("t2_dm_req_addr", dn_if.req_addr, (k % 2 == 0) ? 9'h0A0 : 9'h0B0);
      check("t2_dm_req_data", dn_if.req_data,
            (k % 2 == 0) ? 32'h2222_2222 : 32'h1111_1111);
      dm_complete(32'h100 + k, DMI_RSP_OK);
      check("t2_rsp_valid", up_if.rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("t2_rsp_data", up_if.rsp_data, 32'h100 + k);
      tick();
    end

    // Downstream stalls acceptance for 5 cycles.
    up_if.req_valid = 2'b01;
    up_if.req_addr  = {9'h000, 9'h1A3};
    up_if.req_data  = {32'h0, 32'h1234_5678};
    up_if.req_op    = {DMI_OP_NOP, DMI_OP_WRITE};
    tick();
    up_if.req_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      check("t3_dm_req_valid", dn_if.req_valid, 1'b1);
      check("t3_dm_req_addr", dn_if.req_addr, 9'h1A3);
      check("t3_dm_req_data", dn_if.req_data, 32'h1234_5678);
      check("t3_dm_req_op", dn_if.req_op, DMI_OP_WRITE);
      check("t3_req_ready", up_if.req_ready, 2'b00);
      tick();
    end
    dm_complete(32'h0, DMI_RSP_OK);
    tick();

    // Requester 1 stalls its response; requester 0 waits behind it.
    up_if.rsp_ready = 2'b00;
    up_if.req_valid = 2'b10;
    up_if.req_addr  = {9'h1FF, 9'h000};
    tick();
    check("t4_owner1", owner, 1'b1);
    up_if.req_valid = 2'b00;
    dm_complete(32'hCAFE_F00D, DMI_RSP_BUSY);
    up_if.req_valid = 2'b01;
    up_if.req_addr  = {9'h000, 9'h005};
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t4_rsp_valid", up_if.rsp_valid, 2'b10);
      check("t4_rsp_data", up_if.rsp_data, 32'hCAFE_F00D);
      check("t4_rsp_resp", up_if.rsp_resp, DMI_RSP_BUSY);
      check("t4_req_ready", up_if.req_ready, 2'b00);
      tick();
    end
    up_if.rsp_ready = 2'b10;
    #1;
    check("t4_rsp_valid_hs", up_if.rsp_valid, 2'b10);
    tick();
    check("t4_dead_busy", busy, 1'b0);
    check("t4_dead_req_ready", up_if.req_ready, 2'b01);
    tick();
    check("t4_owner0", owner, 1'b0);
    check("t4_dm_req_addr", dn_if.req_addr, 9'h005);
    up_if.req_valid = 2'b00;
    dm_complete(32'h0BAD_F00D, DMI_RSP_OK);
    up_if.rsp_ready = 2'b11;
    tick();

    // Asynchronous reset while waiting for the downstream response.
    up_if.req_valid = 2'b01;
    up_if.req_addr  = {9'h000, 9'h033};
    tick();
    up_if.req_valid = 2'b00;
    dn_if.req_ready = 1'b1;
    tick();
    dn_if.req_ready = 1'b0;
    check("t5_wait_rsp_ready", dn_if.rsp_ready, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_dm_req_valid", dn_if.req_valid, 1'b0);
    check("t5_rst_dm_rsp_ready", dn_if.rsp_ready, 1'b0);
    check("t5_rst_dm_req_addr", dn_if.req_addr, 9'h000);
    check("t5_rst_rsp_data", up_if.rsp_data, 32'h0);
    check("t5_rst_rsp_resp", up_if.rsp_resp, 2'b00);
    #1;
    reset_n = 1'b1;
    tick();
    up_if.req_valid = 2'b10;
    up_if.req_addr  = {9'h077, 9'h000};
    #1;
    check("t5_req_ready", up_if.req_ready, 2'b10);
    tick();
    check("t5_owner", owner, 1'b1);
    check("t5_dm_req_addr", dn_if.req_addr, 9'h077);
    up_if.req_valid = 2'b00;
    dm_complete(32'h0000_600D, DMI_RSP_OK);
    check("t5_rsp_valid", up_if.rsp_valid, 2'b10);
    check("t5_rsp_data", up_if.rsp_data, 32'h0000_600D);
    tick();

`ifdef DMI_ARB_TIMEOUT_EN
    // No downstream response: failure synthesised after 8 WAIT cycles.
    up_if.rsp_ready = 2'b00;
    up_if.req_valid = 2'b01;
    up_if.req_addr  = {9'h000, 9'h044};
    tick();
    up_if.req_valid = 2'b00;
    dn_if.req_ready = 1'b1;
    tick();
    dn_if.req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t6_wait_rsp_valid", up_if.rsp_valid, 2'b00);
      tick();
    end
    check("t6_to_rsp_valid", up_if.rsp_valid, 2'b01);
    check("t6_to_rsp_resp", up_if.rsp_resp, DMI_RSP_FAILED);
    check("t6_to_rsp_data", up_if.rsp_data, 32'h0);
    dn_if.rsp_valid = 1'b1;
    dn_if.rsp_data  = 32'h0000_0055;
    dn_if.rsp_resp  = DMI_RSP_OK;
    #1;
    check("t6_late_rsp_ready", dn_if.rsp_ready, 1'b1);
    tick();
    dn_if.rsp_valid = 1'b0;
    check("t6_late_rsp_data", up_if.rsp_data, 32'h0);
    check("t6_late_rsp_resp", up_if.rsp_resp, DMI_RSP_FAILED);
    up_if.rsp_ready = 2'b01;
    tick();
    check("t6_flag_cleared", dn_if.rsp_ready, 1'b0);
    check("t6_idle_rsp_valid", up_if.rsp_valid, 2'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmi_req_arbiter.md
Name: dmi_req_arbiter

Overview:
- Shares one DMI request/response channel into the debug-module inner block between two requesters.
- Port 0 is the JTAG DTM path. Port 1 is the secondary debug path (system-side debug port).
- Round-robin arbitration; exactly one transaction outstanding; each response is routed back to the requester that issued it.
- Sits in front of the DMI clock-crossing; runs entirely in the DMI clock domain.

Parameters:
- ADDR_W, 9, DMI address width
- DATA_W, 32, DMI data width
- TIMEOUT_CYCLES, 1023, cycles to wait for a downstream response before synthesising a failure (timeout build only)

Ports:
- clock  in  1  DMI-domain clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester request accept
- req_addr  in  2*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  2*DATA_W  packed write data
- req_op  in  4  packed ops, 2 bits each: 0 nop, 1 read, 2 write
- rsp_valid  out  2  per-requester response valid
- rsp_ready  in  2  per-requester response accept
- rsp_data  out  DATA_W  response data, shared by both requesters
- rsp_resp  out  2  response code, shared: 0 success, 2 failed, 3 busy
- dm_req_valid  out  1  downstream request valid
- dm_req_ready  in  1  downstream request accept
- dm_req_addr  out  ADDR_W  downstream address
- dm_req_data  out  DATA_W  downstream write data
- dm_req_op  out  2  downstream op
- dm_rsp_valid  in  1  downstream response valid
- dm_rsp_ready  out  1  downstream response accept
- dm_rsp_data  in  DATA_W  downstream response data
- dm_rsp_resp  in  2  downstream response code
- owner  out  1  index of the current or last granted requester (debug visibility)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all valid/ready outputs 0; rsp_data, rsp_resp, dm_req_* 0; owner 0; busy 0; round-robin pointer favours requester 0.
- State machine: IDLE -> ISSUE -> WAIT -> DELIVER -> IDLE.
- IDLE:
  - If any req_valid is set, grant one requester. When both are valid, grant the one favoured by the pointer.
  - In the same cycle, assert req_ready for the winner only; latch its addr, data and op; set owner; go to ISSUE.
  - The pointer toggles to the non-winner on every grant.
  - Latency from req_valid to dm_req_valid is 1 cycle.
- ISSUE:
  - Hold dm_req_valid=1 with stable latched fields until dm_req_ready.
  - On acceptance go to WAIT. dm_req_valid may not drop before acceptance.
- WAIT:
  - dm_rsp_ready=1.
  - On dm_rsp_valid, latch data and resp, go to DELIVER.
- DELIVER:
  - rsp_valid[owner]=1; the other bit stays 0.
  - Hold until rsp_ready[owner], then go to IDLE.
  - A new grant is not possible in the same cycle as the deliver handshake (1 dead cycle).
- req_ready is 0 in every state except IDLE.
- Both requesters valid every cycle: grants alternate 0,1,0,1.
- A nop op (0) is still forwarded downstream; the arbiter does not interpret ops.
- Unexpected dm_rsp_valid outside WAIT:
  - dm_rsp_ready=0, so the beat is never consumed.
  - Simulation assertion flags it.
- Asynchronous reset mid-transaction returns to IDLE immediately; the in-flight response is dropped.
- A requester deasserting req_valid before the grant is legal; the arbiter re-evaluates each IDLE cycle.

Optional Feature:
- Macro: DMI_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without dm_rsp_valid, go to DELIVER with rsp_resp=2 and rsp_data=0.
  - Set a sticky flag that masks exactly one following dm_rsp_valid beat: accepted and discarded.
  - The flag clears when that beat is discarded, or on reset.
  - dm_rsp_valid arriving in the same cycle the count is reached wins: real response, no timeout.
- Without the macro: no counter, no flag; WAIT is unbounded.

Decomposition:
- Shared package dmi_pkg:
  - op constants DMI_OP_NOP/READ/WRITE.
  - resp constants DMI_RSP_OK/FAILED/BUSY.
  - a request struct (addr, data, op) and a response struct (data, resp).
  - state enum.
- One natural sub-module: dmi_rr_arb2, the 2-way round-robin pointer and grant logic.

Test Plan:
- Single read from requester 0, addr 0x11, downstream returns data 0xDEADBEEF resp 0:
  - dm_req_valid one cycle after the grant;
  - rsp_valid=2'b01 with data 0xDEADBEEF, resp 0;
  - owner=0.
- Both requesters hold writes continuously for 4 transactions:
  - grant order 0,1,0,1;
  - each rsp_valid lands only on the matching owner bit.
- dm_req_ready held low 5 cycles:
  - dm_req_valid and fields stay stable all 5 cycles;
  - req_ready stays 2'b00 throughout.
- rsp_ready[1] held low 3 cycles in DELIVER:
  - response held stable;
  - no new grant even with req_valid=2'b01;
  - grant follows the deliver handshake plus 1 idle cycle.
- reset_n pulsed low during WAIT:
  - all outputs return to reset values asynchronously;
  - the next request from requester 1 is granted normally.
- DMI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no downstream response:
  - rsp_resp=2 and rsp_data=0 after 8 WAIT cycles;
  - a late dm_rsp_valid is consumed and not forwarded.
